// File: rtl/scc_pkg.sv
// Shared types and constants for the SCC job scheduler.
package scc_pkg;

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      WAIT  = 3'd1,
      START = 3'd2,
      RUN   = 3'd3,
      RESP  = 3'd4
   } sched_state_e;

   localparam int IRQ_DONE_BIT  = 0;
   localparam int IRQ_ERR_BIT   = 1;
   localparam int LVL_WIDTH_DEF = 11;

endpackage

// File: rtl/scc_job_sched_if.sv
// Requester-side bundle: level requests with per-port lengths, grant and response pulses.
interface scc_job_sched_if
   import scc_pkg::*;
#(
   parameter int PORTS     = 3,
   parameter int LVL_WIDTH = LVL_WIDTH_DEF
);
   logic [PORTS-1:0]           req;
   logic [PORTS*LVL_WIDTH-1:0] req_len;
   logic [PORTS-1:0]           gnt;
   logic [PORTS-1:0]           rsp_done;
   logic [PORTS-1:0]           rsp_err;

   modport master (output req, req_len, input gnt, rsp_done, rsp_err);
   modport slave  (input req, req_len, output gnt, rsp_done, rsp_err);
endinterface

// File: rtl/scc_rr_arb.sv
// Round-robin picker: first requester at or above ptr, wrapping; one-hot grant.
// Latency: combinational; backpressure: none, the caller decides when to accept the pick.
module scc_rr_arb #(
   parameter int PORTS = 3,
   parameter int PTR_W = $clog2(PORTS)
) (
   input  logic [PORTS-1:0] req,
   input  logic [PTR_W-1:0] ptr,
   output logic [PORTS-1:0] gnt
);

   always_comb begin
      logic             found;
      logic [PTR_W-1:0] idx;
      gnt   = '0;
      found = 1'b0;
      idx   = '0;
      for (int i = 0; i < PORTS; i++) begin
         idx = PTR_W'((int'(ptr) + i) % PORTS);
         if (!found && req[idx]) begin
            gnt[idx] = 1'b1;
            found    = 1'b1;
         end
      end
   end

endmodule

// File: rtl/scc_job_sched.sv
// Round-robin job scheduler for the SCC core with sticky irqs; stats counters under SCC_SCHED_STATS_EN.
// Latency: grant 1 cycle after a request in IDLE, response pulse the cycle after done/err/timeout;
// backpressure: a granted job waits until the input buffer holds it and the output buffer has room.
module scc_job_sched
   import scc_pkg::*;
#(
   parameter int PORTS     = 3,
   parameter int LVL_WIDTH = LVL_WIDTH_DEF,
   parameter int TO_WIDTH  = 16
) (
   input  logic                     clk_i,
   input  logic                     rst_ni,
   input  logic                     enable_i,
   input  logic [TO_WIDTH-1:0]      timeout_i,
   input  logic [1:0]               irq_clr_i,
   scc_job_sched_if.slave           req_if,
   input  logic [LVL_WIDTH-1:0]     inbf_level_i,
   input  logic [LVL_WIDTH-1:0]     outbf_free_i,
   output logic                     core_start_o,
   output logic [LVL_WIDTH-1:0]     core_len_o,
   input  logic                     core_done_i,
   input  logic                     core_err_i,
   output logic                     busy_o,
   output logic [$clog2(PORTS)-1:0] cur_port_o,
   output logic                     intr_scc_done_o,
   output logic                     intr_scc_err_o,
   output logic [31:0]              job_cnt_o,
   output logic [31:0]              err_cnt_o
);

   localparam int PTR_W = $clog2(PORTS);

   sched_state_e         state_q, state_d;
   logic [PTR_W-1:0]     rr_ptr_q;
   logic [PTR_W-1:0]     arb_idx;
   logic [PORTS-1:0]     arb_gnt;
   logic [LVL_WIDTH-1:0] arb_len;
   logic [TO_WIDTH-1:0]  to_cnt_q;
   logic [PORTS-1:0]     port_oh;
   logic [PORTS-1:0]     gnt_d, rsp_done_d, rsp_err_d;
   logic                 grant_go, data_ok, timed_out;

   scc_rr_arb #(.PORTS(PORTS), .PTR_W(PTR_W)) u_arb (
      .req (req_if.req),
      .ptr (rr_ptr_q),
      .gnt (arb_gnt)
   );

   always_comb begin
      arb_idx = '0;
      arb_len = '0;
      for (int i = 0; i < PORTS; i++) begin
         if (arb_gnt[i]) begin
            arb_idx = PTR_W'(i);
            arb_len = req_if.req_len[i*LVL_WIDTH +: LVL_WIDTH];
         end
      end
   end

   assign grant_go  = (state_q == IDLE) && enable_i && (|req_if.req);
   assign data_ok   = (inbf_level_i >= core_len_o) && (outbf_free_i >= core_len_o);
   assign timed_out = (timeout_i != '0) && (to_cnt_q == timeout_i - 1'b1);
   assign port_oh   = PORTS'(1) << cur_port_o;

   // Response pulses are produced on the transition into RESP so they show during RESP.
   always_comb begin
      state_d    = state_q;
      gnt_d      = '0;
      rsp_done_d = '0;
      rsp_err_d  = '0;
      case (state_q)
         IDLE: begin
            if (grant_go) begin
               gnt_d   = arb_gnt;
               state_d = WAIT;
            end
         end
         WAIT: begin
            if (core_len_o == '0) begin
               rsp_err_d = port_oh;
               state_d   = RESP;
            end else if (data_ok) begin
               state_d = START;
            end
         end
         START: state_d = RUN;
         RUN: begin
            if (core_err_i || (!core_done_i && timed_out)) begin
               rsp_err_d = port_oh;
               state_d   = RESP;
            end else if (core_done_i) begin
               rsp_done_d = port_oh;
               state_d    = RESP;
            end
         end
         RESP:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q         <= IDLE;
         rr_ptr_q        <= '0;
         to_cnt_q        <= '0;
         cur_port_o      <= '0;
         core_len_o      <= '0;
         core_start_o    <= 1'b0;
         busy_o          <= 1'b0;
         req_if.gnt      <= '0;
         req_if.rsp_done <= '0;
         req_if.rsp_err  <= '0;
         intr_scc_done_o <= 1'b0;
         intr_scc_err_o  <= 1'b0;
      end else begin
         state_q         <= state_d;
         busy_o          <= (state_d != IDLE);
         core_start_o    <= (state_q == START);
         req_if.gnt      <= gnt_d;
         req_if.rsp_done <= rsp_done_d;
         req_if.rsp_err  <= rsp_err_d;
         if (grant_go) begin
            cur_port_o <= arb_idx;
            core_len_o <= arb_len;
            rr_ptr_q   <= (arb_idx == PTR_W'(PORTS-1)) ? '0 : arb_idx + 1'b1;
         end
         if (state_q == START)
            to_cnt_q <= '0;
         else if (state_q == RUN)
            to_cnt_q <= to_cnt_q + 1'b1;
         // A set in the same cycle as a clear wins.
         intr_scc_done_o <= (|rsp_done_d) | (intr_scc_done_o & ~irq_clr_i[IRQ_DONE_BIT]);
         intr_scc_err_o  <= (|rsp_err_d)  | (intr_scc_err_o  & ~irq_clr_i[IRQ_ERR_BIT]);
      end
   end

`ifdef SCC_SCHED_STATS_EN
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         job_cnt_o <= '0;
         err_cnt_o <= '0;
      end else begin
         if (|rsp_done_d) job_cnt_o <= job_cnt_o + 32'd1;
         if (|rsp_err_d)  err_cnt_o <= err_cnt_o + 32'd1;
      end
   end
`else
   assign job_cnt_o = '0;
   assign err_cnt_o = '0;
`endif

endmodule
